dma_burst_ctrl: RTL and testbench

DMA transfer sequencer that sits directly upstream of the AXI master. It takes one copy descriptor (source address, destination address, length in 32-bit words), splits it into AXI-legal bursts, and drives the master's read and write control ports. For each chunk it issues the read and the write side together and waits for both done indications before moving on. When the last chunk completes it raises a one-cycle completion pulse.

---
 rtl/dma_burst_ctrl_if.sv | 34 +++
 rtl/dma_burst_ctrl.sv | 114 +++++++++++
 tb/tb_dma_burst_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/dma_burst_ctrl_if.sv
// Descriptor, status and per-chunk read/write control bundle between the DMA sequencer and its neighbours.
// master = sequencer side, slave = descriptor source / AXI master side.
interface dma_burst_ctrl_if #(
    parameter int ADDR_WIDTH      = 32,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int LEN_WIDTH       = 16
);
    logic                       cfg_start;
    logic [ADDR_WIDTH-1:0]      cfg_src_addr;
    logic [ADDR_WIDTH-1:0]      cfg_dst_addr;
    logic [LEN_WIDTH-1:0]       cfg_len;
    logic                       cfg_busy;
    logic                       cfg_done;
    logic                       start_read;
    logic [ADDR_WIDTH-1:0]      target_read_addr;
    logic [BURST_LEN_WIDTH-1:0] target_read_burst_len;
    logic                       done_read;
    logic                       start_write;
    logic [ADDR_WIDTH-1:0]      target_write_addr;
    logic [BURST_LEN_WIDTH-1:0] target_write_burst_len;
    logic                       done_write;

    modport master (
        input  cfg_start, cfg_src_addr, cfg_dst_addr, cfg_len, done_read, done_write,
        output cfg_busy, cfg_done, start_read, target_read_addr, target_read_burst_len,
               start_write, target_write_addr, target_write_burst_len
    );

    modport slave (
        output cfg_start, cfg_src_addr, cfg_dst_addr, cfg_len, done_read, done_write,
        input  cfg_busy, cfg_done, start_read, target_read_addr, target_read_burst_len,
               start_write, target_write_addr, target_write_burst_len
    );
endinterface

// File: rtl/dma_burst_ctrl.sv
// Splits one copy descriptor into bursts; start pulses 1 cycle after accept, next chunk 1 cycle after both dones.
// Waits indefinitely for both dones per chunk; optional 4 KB split via DMA_4K_BOUNDARY_SPLIT_EN.
module dma_burst_ctrl #(
    parameter int ADDR_WIDTH      = 32,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int LEN_WIDTH       = 16,
    parameter int MAX_BEATS       = 16
) (
    input  logic             clk,
    input  logic             rst,
    dma_burst_ctrl_if.master bus
);
    localparam int CW = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FIN} state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [ADDR_WIDTH-1:0]      r_src_ptr;
    logic [ADDR_WIDTH-1:0]      r_dst_ptr;
    logic [LEN_WIDTH-1:0]       r_rem;
    logic [ADDR_WIDTH-1:0]      r_rd_addr;
    logic [ADDR_WIDTH-1:0]      r_wr_addr;
    logic [BURST_LEN_WIDTH-1:0] r_burst_len;
    logic                       r_rd_seen;
    logic                       r_wr_seen;
    logic                       r_zero_len;

    logic [ADDR_WIDTH-1:0]      w_cur_src;
    logic [ADDR_WIDTH-1:0]      w_cur_dst;
    logic [LEN_WIDTH-1:0]       w_cur_rem;
    logic [CW-1:0]              w_rem_cap;
    logic [CW-1:0]              w_beats;
    logic [ADDR_WIDTH-1:0]      w_step;
    logic                       w_chunk_done;

    // Chunk is computed on entry to ISSUE so target_* are valid alongside the start pulse.
    assign w_cur_src = (r_state == S_IDLE) ? (bus.cfg_src_addr & ~ADDR_WIDTH'(3)) : r_src_ptr;
    assign w_cur_dst = (r_state == S_IDLE) ? (bus.cfg_dst_addr & ~ADDR_WIDTH'(3)) : r_dst_ptr;
    assign w_cur_rem = (r_state == S_IDLE) ? bus.cfg_len : r_rem;
    assign w_rem_cap = (CW'(w_cur_rem) > CW'(MAX_BEATS)) ? CW'(MAX_BEATS) : CW'(w_cur_rem);

`ifdef DMA_4K_BOUNDARY_SPLIT_EN
    logic [CW-1:0] w_src_4k;
    logic [CW-1:0] w_dst_4k;
    assign w_src_4k = CW'(13'd4096 - {1'b0, w_cur_src[11:0]}) >> 2;
    assign w_dst_4k = CW'(13'd4096 - {1'b0, w_cur_dst[11:0]}) >> 2;

    always_comb begin
        w_beats = w_rem_cap;
        if (w_beats > w_src_4k) w_beats = w_src_4k;
        if (w_beats > w_dst_4k) w_beats = w_dst_4k;
    end
`else
    assign w_beats = w_rem_cap;
`endif

    assign w_step       = ADDR_WIDTH'({w_beats, 2'b00});
    assign w_chunk_done = (r_rd_seen | bus.done_read) & (r_wr_seen | bus.done_write);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.cfg_start) w_next = (bus.cfg_len == '0) ? S_FIN : S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (w_chunk_done) w_next = (r_rem == '0) ? S_FIN : S_ISSUE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.start_read             = (r_state == S_ISSUE);
        bus.start_write            = (r_state == S_ISSUE);
        bus.cfg_done               = (r_state == S_FIN);
        bus.cfg_busy               = (r_state != S_IDLE) && !((r_state == S_FIN) && r_zero_len);
        bus.target_read_addr       = r_rd_addr;
        bus.target_write_addr      = r_wr_addr;
        bus.target_read_burst_len  = r_burst_len;
        bus.target_write_burst_len = r_burst_len;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_src_ptr   <= '0;
            r_dst_ptr   <= '0;
            r_rem       <= '0;
            r_rd_addr   <= '0;
            r_wr_addr   <= '0;
            r_burst_len <= '0;
            r_rd_seen   <= 1'b0;
            r_wr_seen   <= 1'b0;
            r_zero_len  <= 1'b0;
        end else begin
            if (w_next == S_ISSUE) begin
                r_rd_addr   <= w_cur_src;
                r_wr_addr   <= w_cur_dst;
                r_burst_len <= BURST_LEN_WIDTH'(w_beats - CW'(1));
                r_src_ptr   <= w_cur_src + w_step;
                r_dst_ptr   <= w_cur_dst + w_step;
                r_rem       <= w_cur_rem - LEN_WIDTH'(w_beats);
            end
            if (r_state == S_IDLE && bus.cfg_start)
                r_zero_len <= (bus.cfg_len == '0);
            // Latches only live while a chunk is outstanding; anything else clears them.
            r_rd_seen <= (r_state == S_WAIT) && (w_next == S_WAIT) && (r_rd_seen | bus.done_read);
            r_wr_seen <= (r_state == S_WAIT) && (w_next == S_WAIT) && (r_wr_seen | bus.done_write);
        end
    end
endmodule

// File: tb/tb_dma_burst_ctrl.sv
// Directed bench for dma_burst_ctrl: descriptor table plus hand-written corner sequences.
module tb_dma_burst_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dma_burst_ctrl_if #(.ADDR_WIDTH(32), .BURST_LEN_WIDTH(8), .LEN_WIDTH(16)) bus ();

    dma_burst_ctrl #(
        .ADDR_WIDTH(32), .BURST_LEN_WIDTH(8), .LEN_WIDTH(16), .MAX_BEATS(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0]       src;
        logic [31:0]       dst;
        logic [15:0]       len;
        int                rd_dly;
        int                wr_dly;
        int                n;
        logic [3:0][31:0]  ers;
        logic [3:0][31:0]  ews;
        logic [3:0][7:0]   ebl;
    } vec_t;

    vec_t vecs [6];
    int   n_pass   = 0;
    int   n_checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_desc(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len);
        bus.cfg_src_addr = src;
        bus.cfg_dst_addr = dst;
        bus.cfg_len      = len;
        bus.cfg_start    = 1'b1;
        tick();
        bus.cfg_start    = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int extra;
        int lat;
        start_desc(v.src, v.dst, v.len);
        for (int k = 0; k < v.n; k++) begin
            check($sformatf("%s start%0d", tag, k), {bus.start_read, bus.start_write}, 2'b11);
            check($sformatf("%s rd_addr%0d", tag, k), bus.target_read_addr, v.ers[k]);
            check($sformatf("%s wr_addr%0d", tag, k), bus.target_write_addr, v.ews[k]);
            check($sformatf("%s bl%0d", tag, k),
                  {bus.target_read_burst_len, bus.target_write_burst_len}, {v.ebl[k], v.ebl[k]});
            check($sformatf("%s busy%0d", tag, k), bus.cfg_busy, 1'b1);
            extra = 0;
            lat   = (v.rd_dly > v.wr_dly) ? v.rd_dly : v.wr_dly;
            for (int c = 1; c <= lat; c++) begin
                tick();
                if (bus.start_read || bus.start_write || bus.cfg_done) extra++;
                bus.done_read  = (c == v.rd_dly);
                bus.done_write = (c == v.wr_dly);
            end
            tick();
            bus.done_read  = 1'b0;
            bus.done_write = 1'b0;
            check($sformatf("%s quiet%0d", tag, k), extra, 0);
        end
        check({tag, " done"}, {bus.cfg_done, bus.start_read, bus.start_write, bus.cfg_busy}, 4'b1001);
        tick();
        check({tag, " idle"}, {bus.cfg_done, bus.start_read, bus.start_write, bus.cfg_busy}, 4'b0000);
    endtask

    initial begin
        int extra;
        vecs[0] = '{src: 32'h1000, dst: 32'h8000, len: 16'd40, rd_dly: 3, wr_dly: 3, n: 3,
                    ers: {32'h0, 32'h1080, 32'h1040, 32'h1000},
                    ews: {32'h0, 32'h8080, 32'h8040, 32'h8000},
                    ebl: {8'd0, 8'd7, 8'd15, 8'd15}};
        vecs[1] = '{src: 32'h0, dst: 32'h100, len: 16'd16, rd_dly: 3, wr_dly: 1, n: 1,
                    ers: {96'h0, 32'h0}, ews: {96'h0, 32'h100}, ebl: {24'h0, 8'd15}};
        vecs[2] = '{src: 32'h0, dst: 32'h100, len: 16'd16, rd_dly: 2, wr_dly: 2, n: 1,
                    ers: {96'h0, 32'h0}, ews: {96'h0, 32'h100}, ebl: {24'h0, 8'd15}};
`ifdef DMA_4K_BOUNDARY_SPLIT_EN
        vecs[3] = '{src: 32'h1FF0, dst: 32'h3000, len: 16'd8, rd_dly: 1, wr_dly: 1, n: 2,
                    ers: {64'h0, 32'h2000, 32'h1FF0}, ews: {64'h0, 32'h3010, 32'h3000},
                    ebl: {16'h0, 8'd3, 8'd3}};
`else
        vecs[3] = '{src: 32'h1FF0, dst: 32'h3000, len: 16'd8, rd_dly: 1, wr_dly: 1, n: 1,
                    ers: {96'h0, 32'h1FF0}, ews: {96'h0, 32'h3000}, ebl: {24'h0, 8'd7}};
`endif
        vecs[4] = '{src: 32'hFFFF_FFC0, dst: 32'h20, len: 16'd17, rd_dly: 2, wr_dly: 1, n: 2,
                    ers: {64'h0, 32'h0, 32'hFFFF_FFC0}, ews: {64'h0, 32'h60, 32'h20},
                    ebl: {16'h0, 8'd0, 8'd15}};
        vecs[5] = '{src: 32'h2003, dst: 32'h4002, len: 16'd5, rd_dly: 1, wr_dly: 2, n: 1,
                    ers: {96'h0, 32'h2000}, ews: {96'h0, 32'h4000}, ebl: {24'h0, 8'd4}};

        rst = 1'b1;
        bus.cfg_start = 1'b0; bus.cfg_src_addr = '0; bus.cfg_dst_addr = '0; bus.cfg_len = '0;
        bus.done_read = 1'b0; bus.done_write = 1'b0;
        tick(); tick(); tick();
        check("reset ctl", {bus.cfg_busy, bus.cfg_done, bus.start_read, bus.start_write}, 4'b0000);
        check("reset addr", {bus.target_read_addr, bus.target_write_addr}, 64'h0);
        check("reset bl", {bus.target_read_burst_len, bus.target_write_burst_len}, 16'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // zero length: done one cycle after accept, never busy, no bursts
        start_desc(32'h10, 32'h20, 16'd0);
        check("zero T+1", {bus.cfg_done, bus.start_read, bus.start_write, bus.cfg_busy}, 4'b1000);
        tick();
        check("zero T+2", {bus.cfg_done, bus.start_read, bus.start_write, bus.cfg_busy}, 4'b0000);

        // new descriptor during WAIT is dropped
        start_desc(32'h1000, 32'h8000, 16'd16);
        check("ign start", {bus.start_read, bus.start_write}, 2'b11);
        tick();
        bus.cfg_src_addr = 32'h5000; bus.cfg_dst_addr = 32'h6000; bus.cfg_len = 16'd4;
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        check("ign no start", {bus.start_read, bus.start_write, bus.cfg_done}, 3'b000);
        bus.done_read = 1'b1; bus.done_write = 1'b1;
        tick();
        bus.done_read = 1'b0; bus.done_write = 1'b0;
        check("ign done", bus.cfg_done, 1'b1);
        check("ign addrs", {bus.target_read_addr, bus.target_write_addr}, {32'h1000, 32'h8000});
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.start_read || bus.start_write || bus.cfg_done) extra++;
        end
        check("ign not queued", extra, 0);

        // reset in WAIT after first chunk
        start_desc(32'h1000, 32'h8000, 16'd40);
        check("rst first start", {bus.start_read, bus.start_write}, 2'b11);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst ctl", {bus.cfg_busy, bus.cfg_done, bus.start_read, bus.start_write}, 4'b0000);
        check("rst addr", {bus.target_read_addr, bus.target_write_addr}, 64'h0);
        check("rst bl", {bus.target_read_burst_len, bus.target_write_burst_len}, 16'h0);
        bus.done_read = 1'b1; bus.done_write = 1'b1;
        tick();
        bus.done_read = 1'b0; bus.done_write = 1'b0;
        extra = 0;
        for (int c = 0; c < 5; c++) begin
            if (bus.start_read || bus.start_write || bus.cfg_done || bus.cfg_busy) extra++;
            tick();
        end
        check("rst late done", extra, 0);
        run_vec(vecs[0], "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
